// File: rtl/btc_regs_pkg.sv
// Shared register map, bit positions and FSM encodings for the BtcMiner Wishbone front-end.
package btc_regs_pkg;

  // Word indices (byte offset >> 2)
  localparam logic [5:0] W_CTRL   = 6'h00;
  localparam logic [5:0] W_STATUS = 6'h01;
  localparam logic [5:0] W_MID0   = 6'h02;
  localparam logic [5:0] W_MERKLE = 6'h0A;
  localparam logic [5:0] W_NTIME  = 6'h0B;
  localparam logic [5:0] W_NBITS  = 6'h0C;
  localparam logic [5:0] W_NSTART = 6'h0D;
  localparam logic [5:0] W_NEND   = 6'h0E;
  localparam logic [5:0] W_RESULT = 6'h0F;

  // MIDSTATE0..7, MERKLE_TAIL, NTIME, NBITS, NONCE_START, NONCE_END
  localparam int JOB_WORDS = 13;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t S_IDLE  = 2'd0;
  localparam fsm_state_t S_OFFER = 2'd1;
  localparam fsm_state_t S_RUN   = 2'd2;

  function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/btc_result_fifo.sv
// First-word-fall-through result FIFO; pointers carry an extra MSB so full/empty/count fall out of subtraction.
module btc_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic                       pop,
  output logic [31:0]                head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_pop;
  logic        do_push;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/btc_wb_regs.sv
// Wishbone classic register front-end for BtcMiner: job registers, job handshake FSM, result FIFO and irq.
module btc_wb_regs
  import btc_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              wb_cycle,
  input  logic              wb_strobe,
  input  logic              wb_we,
  input  logic [3:0]        wb_sel,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_wdata,
  output logic              wb_ack,
  output logic [31:0]       wb_rdata,
  output logic              job_valid,
  input  logic              job_ready,
  output logic [255:0]      job_midstate,
  output logic [95:0]       job_data,
  output logic [31:0]       job_nonce_start,
  output logic [31:0]       job_nonce_end,
  output logic              core_abort,
  input  logic              core_done,
  input  logic              res_valid,
  input  logic [31:0]       res_nonce,
  output logic              irq
);
  localparam int WI = ADDR_W - 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        ack_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  fsm_state_t  state_reg;
  logic        core_abort_reg;
  logic        irq_en_reg;
  logic        ovf_reg;
  logic [31:0] job_regs [JOB_WORDS];

  logic          access, wr_access, rd_access;
  logic [WI-1:0] word_idx;
  logic [3:0]    job_idx;
  logic          busy;
  logic          ctrl_wr, status_wr, start_req, abort_req, result_rd;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^wb_addr[1:0];

  assign access    = wb_cycle & wb_strobe & ~ack_reg;
  assign wr_access = access & wb_we;
  assign rd_access = access & ~wb_we;
  assign word_idx  = wb_addr[ADDR_W-1:2];
  assign job_idx   = 4'(word_idx - WI'(W_MID0));
  assign busy      = (state_reg != S_IDLE);

  assign ctrl_wr   = wr_access && (word_idx == WI'(W_CTRL)) && wb_sel[0];
  assign status_wr = wr_access && (word_idx == WI'(W_STATUS)) && wb_sel[0];
  assign start_req = ctrl_wr & wb_wdata[CTRL_START];
  assign abort_req = ctrl_wr & wb_wdata[CTRL_ABORT];
  assign result_rd = rd_access && (word_idx == WI'(W_RESULT));

  btc_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .push      (res_valid),
    .push_data (res_nonce),
    .pop       (result_rd),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_reg      <= S_IDLE;
      core_abort_reg <= 1'b0;
    end else begin
      core_abort_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_req && !abort_req) state_reg <= S_OFFER;
        end
        S_OFFER: begin
          if (abort_req) begin
            state_reg      <= S_IDLE;
            core_abort_reg <= 1'b1;
          end else if (job_ready) begin
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_req) begin
            state_reg      <= S_IDLE;
            core_abort_reg <= 1'b1;
          end else if (core_done) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_reg <= wb_wdata[CTRL_IRQ_EN];
      // A dropped result outranks a simultaneous W1C so the loss is never hidden.
      if (res_valid && fifo_full && !result_rd) ovf_reg <= 1'b1;
      else if (status_wr && wb_wdata[STAT_OVF]) ovf_reg <= 1'b0;
    end
  end

  // Job words are frozen while a job is outstanding so the core sees stable inputs.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < JOB_WORDS; i++) job_regs[i] <= '0;
    end else begin
      for (int i = 0; i < JOB_WORDS; i++) begin
        if (wr_access && !busy && (word_idx == WI'(int'(W_MID0) + i)))
          job_regs[i] <= sel_merge(job_regs[i], wb_wdata, wb_sel);
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    if (word_idx == WI'(W_CTRL)) begin
      rdata_next[CTRL_IRQ_EN] = irq_en_reg;
    end else if (word_idx == WI'(W_STATUS)) begin
      rdata_next[STAT_BUSY]                = busy;
      rdata_next[STAT_EMPTY]               = fifo_empty;
      rdata_next[STAT_FULL]                = fifo_full;
      rdata_next[STAT_OVF]                 = ovf_reg;
      rdata_next[STAT_CNT_LSB +: 4]        = 4'(fifo_count);
    end else if (word_idx >= WI'(W_MID0) && word_idx <= WI'(W_NEND)) begin
      rdata_next = job_regs[job_idx];
    end else if (word_idx == WI'(W_RESULT)) begin
      rdata_next = fifo_empty ? 32'hFFFF_FFFF : fifo_head;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg   <= access;
      rdata_reg <= rd_access ? rdata_next : 32'd0;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_mid
    assign job_midstate[gi*32 +: 32] = job_regs[gi];
  end

  assign job_data        = {job_regs[W_NBITS - W_MID0], job_regs[W_NTIME - W_MID0],
                            job_regs[W_MERKLE - W_MID0]};
  assign job_nonce_start = job_regs[W_NSTART - W_MID0];
  assign job_nonce_end   = job_regs[W_NEND - W_MID0];

  assign wb_ack     = ack_reg;
  assign wb_rdata   = rdata_reg;
  // Gated by reset so the offer is withdrawn in the very cycle reset is asserted.
  assign job_valid  = (state_reg == S_OFFER) & wb_rst_n;
  assign core_abort = core_abort_reg;
  assign irq        = irq_en_reg & ~fifo_empty;

endmodule

// File: tb/tb_btc_wb_regs.sv
// Directed bench for btc_wb_regs: register map vectors plus job FSM, abort, reset and FIFO corner sequences.
module tb_btc_wb_regs;
  logic         wb_clk = 1'b0;
  logic         wb_rst_n = 1'b0;
  logic         wb_cycle = 1'b0, wb_strobe = 1'b0, wb_we = 1'b0;
  logic [3:0]   wb_sel = 4'h0;
  logic [7:0]   wb_addr = 8'h0;
  logic [31:0]  wb_wdata = 32'h0;
  logic         wb_ack;
  logic [31:0]  wb_rdata;
  logic         job_valid;
  logic         job_ready = 1'b0;
  logic [255:0] job_midstate;
  logic [95:0]  job_data;
  logic [31:0]  job_nonce_start, job_nonce_end;
  logic         core_abort;
  logic         core_done = 1'b0;
  logic         res_valid = 1'b0;
  logic [31:0]  res_nonce = 32'h0;
  logic         irq;

  int n_pass = 0;
  int n_total = 0;
  int abort_cnt = 0;

  always #5 wb_clk = ~wb_clk;

  btc_wb_regs dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_cycle(wb_cycle), .wb_strobe(wb_strobe),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_ack(wb_ack), .wb_rdata(wb_rdata), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_data(job_data), .job_nonce_start(job_nonce_start),
    .job_nonce_end(job_nonce_end), .core_abort(core_abort), .core_done(core_done),
    .res_valid(res_valid), .res_nonce(res_nonce), .irq(irq)
  );

  always @(negedge wb_clk) if (core_abort) abort_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input logic push, input logic [31:0] pnonce,
                         output logic [31:0] rd, output int lat);
    @(negedge wb_clk);
    wb_cycle = 1'b1; wb_strobe = 1'b1; wb_we = we;
    wb_addr = addr; wb_sel = sel; wb_wdata = wd;
    if (push) begin res_valid = 1'b1; res_nonce = pnonce; end
    lat = 0;
    do begin
      @(posedge wb_clk); #1;
      res_valid = 1'b0;
      lat++;
    end while (!wb_ack && lat < 8);
    rd = wb_rdata;
    if (!wb_ack) chk("ack_timeout", {31'b0, wb_ack}, 32'd1);
    @(negedge wb_clk);
    wb_cycle = 1'b0; wb_strobe = 1'b0; wb_we = 1'b0;
    $display("wb %s addr=0x%02h sel=%b wdata=0x%08h rdata=0x%08h lat=%0d",
             we ? "WR" : "RD", addr, sel, wd, rd, lat);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy; int l;
    wb_xfer(1'b1, a, 4'hF, d, 1'b0, 32'h0, dummy, l);
  endtask

  task automatic rdc(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d; int l;
    wb_xfer(1'b0, a, 4'hF, 32'h0, 1'b0, 32'h0, d, l);
    chk(name, d, exp);
  endtask

  task automatic res_pulse(input logic [31:0] n);
    @(negedge wb_clk); res_valid = 1'b1; res_nonce = n;
    @(negedge wb_clk); res_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] d;
    int lat, hi, a0;

    // After reset every offset reads 0 except STATUS (empty) and RESULT (empty marker).
    for (int a = 0; a <= 'h3C; a += 4)
      vecs.push_back('{1'b0, 8'(a), 4'hF, 32'h0,
                      (a == 4) ? 32'h2 : (a == 'h3C) ? 32'hFFFF_FFFF : 32'h0});
    vecs.push_back('{1'b0, 8'h80, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 8'h08, 4'b0011, 32'h6A09E667, 32'h0});
    vecs.push_back('{1'b0, 8'h08, 4'hF, 32'h0, 32'h0000E667});
    vecs.push_back('{1'b1, 8'h0C, 4'b1100, 32'hBB6710AA, 32'h0});
    vecs.push_back('{1'b0, 8'h0C, 4'hF, 32'h0, 32'hBB670000});
    vecs.push_back('{1'b1, 8'h28, 4'hF, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b1, 8'h2C, 4'hF, 32'h5F5E1000, 32'h0});
    vecs.push_back('{1'b1, 8'h30, 4'hF, 32'h1703A30C, 32'h0});
    vecs.push_back('{1'b1, 8'h34, 4'hF, 32'h00000100, 32'h0});
    vecs.push_back('{1'b1, 8'h38, 4'hF, 32'h000001FF, 32'h0});
    vecs.push_back('{1'b0, 8'h28, 4'hF, 32'h0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 8'h38, 4'hF, 32'h0, 32'h000001FF});
    vecs.push_back('{1'b1, 8'h3C, 4'hF, 32'h00001234, 32'h0});
    vecs.push_back('{1'b0, 8'h3C, 4'hF, 32'h0, 32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 8'h80, 4'hF, 32'h0000FFFF, 32'h0});
    vecs.push_back('{1'b0, 8'h80, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 8'h04, 4'hF, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{1'b0, 8'h04, 4'hF, 32'h0, 32'h2});

    // Reset state
    repeat (3) @(negedge wb_clk);
    chk("rst_ack", {31'b0, wb_ack}, 32'd0);
    chk("rst_rdata", wb_rdata, 32'd0);
    chk("rst_job_valid", {31'b0, job_valid}, 32'd0);
    chk("rst_core_abort", {31'b0, core_abort}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    wb_rst_n = 1'b1;

    foreach (vecs[i]) begin
      wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, 1'b0, 32'h0, d, lat);
      if (!vecs[i].we) chk($sformatf("vec%0d_rd_0x%02h", i, vecs[i].addr), d, vecs[i].exp);
    end

    // Ack latency and pulse width
    wb_xfer(1'b0, 8'h04, 4'hF, 32'h0, 1'b0, 32'h0, d, lat);
    chk("ack_latency", 32'(lat), 32'd1);
    @(posedge wb_clk); #1;
    chk("ack_one_cycle", {31'b0, wb_ack}, 32'd0);

    chk("out_mid0", job_midstate[31:0], 32'h0000E667);
    chk("out_mid1", job_midstate[63:32], 32'hBB670000);
    chk("out_nbits", job_data[95:64], 32'h1703A30C);
    chk("out_ntime", job_data[63:32], 32'h5F5E1000);
    chk("out_merkle", job_data[31:0], 32'hDEADBEEF);
    chk("out_nstart", job_nonce_start, 32'h100);
    chk("out_nend", job_nonce_end, 32'h1FF);

    // Job offer held while the core is not ready
    job_ready = 1'b0;
    wr(8'h00, 32'h1);
    hi = 0;
    for (int c = 0; c < 5; c++) begin
      if (job_valid) hi++;
      @(negedge wb_clk);
    end
    chk("job_valid_hold", 32'(hi), 32'd5);
    rdc("offer_status", 8'h04, 32'h3);
    wr(8'h08, 32'h12345678);
    job_ready = 1'b1;
    @(posedge wb_clk); #1;
    chk("run_job_valid", {31'b0, job_valid}, 32'd0);
    job_ready = 1'b0;
    rdc("busy_write_ignored", 8'h08, 32'h0000E667);
    rdc("run_status", 8'h04, 32'h3);
    @(negedge wb_clk); core_done = 1'b1;
    @(negedge wb_clk); core_done = 1'b0;
    rdc("done_status", 8'h04, 32'h2);

    // Abort from RUN
    job_ready = 1'b1;
    wr(8'h00, 32'h1);
    @(negedge wb_clk);
    job_ready = 1'b0;
    rdc("run2_status", 8'h04, 32'h3);
    a0 = abort_cnt;
    wr(8'h00, 32'h2);
    @(negedge wb_clk);
    chk("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    rdc("abort_status", 8'h04, 32'h2);

    // start+abort in IDLE does nothing
    a0 = abort_cnt;
    wr(8'h00, 32'h3);
    repeat (2) @(negedge wb_clk);
    chk("idle_abort_no_pulse", 32'(abort_cnt - a0), 32'd0);
    rdc("idle_abort_status", 8'h04, 32'h2);
    chk("idle_abort_job_valid", {31'b0, job_valid}, 32'd0);

    // Start again, then reset in the middle of the offer
    wr(8'h00, 32'h1);
    rdc("restart_status", 8'h04, 32'h3);
    chk("restart_job_valid", {31'b0, job_valid}, 32'd1);
    a0 = abort_cnt;
    @(negedge wb_clk); wb_rst_n = 1'b0;
    #1;
    chk("rst_mid_job_valid", {31'b0, job_valid}, 32'd0);
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("rst_mid_no_abort", 32'(abort_cnt - a0), 32'd0);
    rdc("rst_mid_status", 8'h04, 32'h2);
    rdc("rst_mid_regs", 8'h08, 32'h0);

    // FIFO overflow and drain
    wr(8'h00, 32'h4);
    for (int n = 1; n <= 5; n++) res_pulse(32'(n));
    @(negedge wb_clk);
    chk("irq_set", {31'b0, irq}, 32'd1);
    rdc("ovf_status", 8'h04, 32'h0000040C);
    rdc("ctrl_irq_en", 8'h00, 32'h4);
    for (int n = 1; n <= 4; n++) rdc($sformatf("pop%0d", n), 8'h3C, 32'(n));
    rdc("pop_empty", 8'h3C, 32'hFFFF_FFFF);
    chk("irq_clear", {31'b0, irq}, 32'd0);
    rdc("drained_status", 8'h04, 32'h0000000A);
    wr(8'h04, 32'h8);
    rdc("ovf_w1c", 8'h04, 32'h2);

    // Full FIFO: push coincident with pop
    for (int n = 0; n < 4; n++) res_pulse(32'h10 + 32'(n));
    rdc("full_status", 8'h04, 32'h00000404);
    wb_xfer(1'b0, 8'h3C, 4'hF, 32'h0, 1'b1, 32'hABCD, d, lat);
    chk("pop_push_head", d, 32'h10);
    rdc("pop_push_status", 8'h04, 32'h00000404);
    rdc("pp_pop1", 8'h3C, 32'h11);
    rdc("pp_pop2", 8'h3C, 32'h12);
    rdc("pp_pop3", 8'h3C, 32'h13);
    rdc("pp_pop4", 8'h3C, 32'hABCD);

    // Empty read with simultaneous push
    wb_xfer(1'b0, 8'h3C, 4'hF, 32'h0, 1'b1, 32'h55, d, lat);
    chk("empty_read_push", d, 32'hFFFF_FFFF);
    rdc("empty_push_kept", 8'h3C, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
